div: RTL and testbench

- Multi-cycle radix-2 restoring divider that sits beside the execute stage, which owns it.
- Execute issues DIV/DIVU operands with start_i, holds its own stall request while the divider runs, and consumes {remainder, quotient} to write HI/LO.
- Handles signed and unsigned division, divide-by-zero and annulment on pipeline flush.

---
 rtl/div_pkg.sv | 18 +
 rtl/div.sv | 165 ++++++++++++++++
 tb/tb_div.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divider: state codes and handshake levels.
package div_pkg;

    localparam int unsigned DivWidth = 32;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider owned by execute: one quotient bit per clock,
// signed/unsigned, divide-by-zero shortcut, annul on pipeline flush.
module div
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DivWidth
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    div_state_e           state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     divisor_q, divisor_d;
    logic                 sign_quo_q, sign_quo_d;
    logic                 sign_rem_q, sign_rem_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;

    logic [WIDTH-1:0]     op1_mag_c, op2_mag_c;
    logic [WIDTH:0]       trial_c;
    logic                 go_c;
    logic                 last_c;

    assign op1_mag_c = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
    assign op2_mag_c = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + WIDTH'(1)) : opdata2_i;
    assign go_c      = (start_i == DivStart) && !annul_i;
    assign last_c    = (cnt_q == CntW'(WIDTH));

    // Shifted partial remainder minus divisor; bit WIDTH set means the trial went negative.
    assign trial_c = {rem_q, quo_q[WIDTH-1]} - {1'b0, divisor_q};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DivFree;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; annul wins over iteration and completion
    always_comb begin
        state_d = state_q;
        case (state_q)
            DivFree: begin
                if (go_c) begin
                    state_d = (opdata2_i == '0) ? DivByZero : DivOn;
                end
            end
            DivByZero: state_d = DivEnd;
            DivOn: begin
                if (annul_i) begin
                    state_d = DivFree;
                end else if (last_c) begin
                    state_d = DivEnd;
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    state_d = DivFree;
                end
            end
            default: state_d = DivFree;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        divisor_d  = divisor_q;
        sign_quo_d = sign_quo_q;
        sign_rem_d = sign_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;
        case (state_q)
            DivFree: begin
                ready_d  = DivResultNotReady;
                result_d = '0;
                cnt_d    = '0;
                if (go_c && (opdata2_i != '0)) begin
                    rem_d      = '0;
                    quo_d      = op1_mag_c;
                    divisor_d  = op2_mag_c;
                    sign_quo_d = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    sign_rem_d = signed_div_i & opdata1_i[WIDTH-1];
                end
            end
            DivByZero: begin
                result_d = '0;
                ready_d  = DivResultReady;
            end
            DivOn: begin
                if (annul_i) begin
                    cnt_d    = '0;
                    ready_d  = DivResultNotReady;
                    result_d = '0;
                end else if (!last_c) begin
                    if (!trial_c[WIDTH]) begin
                        rem_d = trial_c[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CntW'(1);
                end else begin
                    result_d = {(sign_rem_q ? (~rem_q + WIDTH'(1)) : rem_q),
                                (sign_quo_q ? (~quo_q + WIDTH'(1)) : quo_q)};
                    ready_d  = DivResultReady;
                    cnt_d    = '0;
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    ready_d  = DivResultNotReady;
                    result_d = '0;
                end
            end
            default: begin
                ready_d  = DivResultNotReady;
                result_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            divisor_q  <= '0;
            sign_quo_q <= 1'b0;
            sign_rem_q <= 1'b0;
            result_q   <= '0;
            ready_q    <= DivResultNotReady;
        end else begin
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            divisor_q  <= divisor_d;
            sign_quo_q <= sign_quo_d;
            sign_rem_q <= sign_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Directed bench for the restoring divider: vector table plus annul/reset/hold sequences.
module tb_div;

    localparam int unsigned W = 32;

    logic           clk;
    logic           rst;
    logic           signed_div;
    logic [W-1:0]   op1;
    logic [W-1:0]   op2;
    logic           start;
    logic           annul;
    logic [2*W-1:0] result;
    logic           ready;

    int pass_cnt;
    int total_cnt;

    typedef struct {
        string      name;
        logic       sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        int         lat;
    } vec_t;

    vec_t vecs[10];

    div #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        signed_div = s;
        op1        = a;
        op2        = b;
        start      = 1'b1;
        annul      = 1'b0;
    endtask

    // Counts edges after the sampling edge until ready rises (bounded).
    task automatic wait_result(input string nm, input int lat, input logic [2*W-1:0] exp);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!ready && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("%s latency", nm), 64'(n), 64'(lat));
        chk($sformatf("%s result", nm), 64'(result), 64'(exp));
    endtask

    task automatic drop_start(input string nm);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("%s drop ready", nm), 64'(ready), 64'd0);
        chk($sformatf("%s drop result", nm), 64'(result), 64'd0);
    endtask

    initial begin
        pass_cnt   = 0;
        total_cnt  = 0;
        rst        = 1'b1;
        signed_div = 1'b0;
        op1        = '0;
        op2        = '0;
        start      = 1'b0;
        annul      = 1'b0;

        vecs[0] = '{"u100/7",     1'b0, 32'd100,        32'd7,          32'h0000000E, 32'h00000002, 33};
        vecs[1] = '{"s-7/2",      1'b1, 32'hFFFFFFF9,   32'h00000002,   32'hFFFFFFFD, 32'hFFFFFFFF, 33};
        vecs[2] = '{"u-7/2",      1'b0, 32'hFFFFFFF9,   32'h00000002,   32'h7FFFFFFC, 32'h00000001, 33};
        vecs[3] = '{"s7/-2",      1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD, 32'h00000001, 33};
        vecs[4] = '{"s-100/-7",   1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'h0000000E, 32'hFFFFFFFE, 33};
        vecs[5] = '{"s/0",        1'b1, 32'hFFFFFFF9,   32'h00000000,   32'h00000000, 32'h00000000, 1};
        vecs[6] = '{"u/0",        1'b0, 32'd5,          32'h00000000,   32'h00000000, 32'h00000000, 1};
        vecs[7] = '{"sMIN/-1",    1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'h00000000, 33};
        vecs[8] = '{"uMAX/1",     1'b0, 32'hFFFFFFFF,   32'h00000001,   32'hFFFFFFFF, 32'h00000000, 33};
        vecs[9] = '{"u3/9",       1'b0, 32'd3,          32'd9,          32'h00000000, 32'h00000003, 33};

        repeat (2) @(posedge clk);
        #1;
        chk("reset ready", 64'(ready), 64'd0);
        chk("reset result", 64'(result), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].sgn, vecs[i].a, vecs[i].b);
            wait_result(vecs[i].name, vecs[i].lat, {vecs[i].r, vecs[i].q});
            drop_start(vecs[i].name);
        end

        // Annul sampled while cnt==10, then an immediate new division
        issue(1'b0, 32'd100, 32'd7);
        @(posedge clk); #1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        annul = 1'b1;
        @(posedge clk); #1;
        chk("annul ready", 64'(ready), 64'd0);
        chk("annul result", 64'(result), 64'd0);
        issue(1'b0, 32'd9, 32'd3);
        wait_result("post-annul 9/3", 33, {32'd0, 32'd3});
        drop_start("post-annul");

        // Synchronous reset while cnt==20 aborts the division
        issue(1'b0, 32'd100, 32'd7);
        @(posedge clk); #1;
        repeat (20) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("midreset ready", 64'(ready), 64'd0);
        chk("midreset result", 64'(result), 64'd0);
        chk("midreset state", 64'(dut.state_q), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready) break;
        end
        chk("after reset idle ready", 64'(ready), 64'd0);

        // END holds its result while start stays high, even if operands change
        issue(1'b1, 32'hFFFFFFF9, 32'h00000002);
        wait_result("hold", 33, {32'hFFFFFFFF, 32'hFFFFFFFD});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            op1 = 32'd1000 + 32'(i);
            op2 = 32'd3;
            @(posedge clk); #1;
            chk($sformatf("hold%0d ready", i), 64'(ready), 64'd1);
            chk($sformatf("hold%0d result", i), 64'(result), {32'hFFFFFFFF, 32'hFFFFFFFD});
        end
        drop_start("hold");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
